// File: rtl/wu_pkt_receiver_pkg.sv
// -----------------------------------------------------------------------------
// wu_pkt_pkg
// Shared definitions for the wake-up packet receiver: receiver FSM states,
// scrambler tap mask and the fixed test pattern carried by every payload byte.
// -----------------------------------------------------------------------------
package wu_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_SAMPLE    = 2'd2
    } state_e;

    // History taps h0, h3, h4, h6, h7 of the self-synchronous x^8 scrambler.
    localparam logic [7:0] SCR_TAPS = 8'hD9;

    // Test pattern; bit 7 is the expected value of the first bit of each byte.
    localparam logic [7:0] PATTERN = 8'hF0;

    // XOR of the tapped history bits.
    function automatic logic tap_xor(input logic [7:0] hist);
        return ^(hist & SCR_TAPS);
    endfunction

endpackage

// File: rtl/wu_pkt_receiver_if.sv
// -----------------------------------------------------------------------------
// wu_pkt_receiver_if
// Control/data bundle between the wake-up control logic (master) and the
// packet receiver (slave).
//   arm          : single-cycle start request (master -> slave)
//   rx_in        : raw comparator stream, asynchronous (master -> slave)
//   payload_bits : payload length in bits, sampled on accepted arm
//   busy         : receiver is handling a request
//   byte_data    : received byte, first bit in bit 7
//   byte_valid   : one-cycle strobe qualifying byte_data
//   pkt_done     : one-cycle pulse after the last payload bit
//   timeout      : one-cycle pulse when no sync edge arrived in time
//   err_count    : saturating count of bits differing from the test pattern
// -----------------------------------------------------------------------------
interface wu_pkt_receiver_if;

    logic        arm;
    logic        rx_in;
    logic [15:0] payload_bits;
    logic        busy;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        pkt_done;
    logic        timeout;
    logic [15:0] err_count;

    modport master (
        output arm, rx_in, payload_bits,
        input  busy, byte_data, byte_valid, pkt_done, timeout, err_count
    );

    modport slave (
        input  arm, rx_in, payload_bits,
        output busy, byte_data, byte_valid, pkt_done, timeout, err_count
    );

endinterface

// File: rtl/wu_pkt_receiver_rx_descrambler.sv
// -----------------------------------------------------------------------------
// rx_descrambler
// Self-synchronous x^8 descrambler: 8-bit history of received channel bits and
// the XOR tap network.
//   clki    : system clock
//   rst     : asynchronous active-high reset
//   i_clr   : clear history (new packet armed)
//   i_shift : accept i_bit into the history this cycle
//   i_bit   : received channel bit
//   o_bit   : descrambled bit for i_bit (combinational)
// -----------------------------------------------------------------------------
module rx_descrambler
    import wu_pkt_pkg::*;
(
    input  logic clki,
    input  logic rst,
    input  logic i_clr,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_bit
);

    logic [7:0] r_hist;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= {r_hist[6:0], i_bit};
        end
    end

    assign o_bit = i_bit ^ tap_xor(r_hist);

endmodule

// File: rtl/wu_pkt_receiver.sv
// -----------------------------------------------------------------------------
// wu_pkt_receiver
// Receives a scrambled wake-up packet: waits for the first rising edge after
// the all-zero preamble, samples every bit at its centre from that single edge,
// descrambles, assembles MSB-first bytes and counts pattern mismatches.
// Parameters:
//   datarate_div : system clocks per data bit (even, >= 4)
//   timeout_cyc  : clocks to wait for the sync edge after arming (>= 1)
// Ports:
//   clki : system clock
//   rst  : asynchronous active-high reset
//   bus  : wu_pkt_receiver_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module wu_pkt_receiver
    import wu_pkt_pkg::*;
#(
    parameter int unsigned datarate_div = 100,
    parameter int unsigned timeout_cyc  = 1000000
) (
    input  logic                 clki,
    input  logic                 rst,
    wu_pkt_receiver_if.slave     bus
);

    localparam logic [15:0] PHASE_HALF   = 16'(datarate_div / 2);
    localparam logic [15:0] PHASE_RELOAD = 16'(datarate_div - 1);
    localparam logic [31:0] WAIT_LAST    = 32'(timeout_cyc - 1);

    state_e      r_state;
    logic [2:0]  r_sync;
    logic [15:0] r_phase;
    logic [31:0] r_wait_cnt;
    logic [15:0] r_len;
    logic [15:0] r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte_data;
    logic        r_byte_valid;
    logic        r_pkt_done;
    logic        r_timeout;
    logic        r_busy;
    logic [15:0] r_err_count;

    logic        w_edge;
    logic        w_arm_ok;
    logic        w_sample;
    logic        w_last;
    logic        w_byte_full;
    logic        w_exp;
    logic        w_d;
    logic [7:0]  w_byte_next;
    logic [7:0]  w_byte_out;

    assign w_edge      = (r_sync[2:1] == 2'b01);
    // busy stays high one cycle past the final pulse, so it also gates arm.
    assign w_arm_ok    = bus.arm && (r_state == ST_IDLE) && !r_busy;
    assign w_sample    = (r_state == ST_SAMPLE) && (r_phase == '0);
    assign w_last      = (r_bit_idx == r_len - 16'd1);
    assign w_byte_full = (r_bit_idx[2:0] == 3'd7);
    assign w_exp       = PATTERN[3'd7 - r_bit_idx[2:0]];
    assign w_byte_next = {r_shift[6:0], w_d};

    // NOTE: combinational blocks assign every output unconditionally so no
    // latch can be inferred.
    always_comb begin
        // Left-align a partial final byte; the shift fills zeros from below
        // and drops leftovers of the previous byte off the top.
        w_byte_out = w_byte_next << (3'd7 - r_bit_idx[2:0]);
    end

    rx_descrambler u_descrambler (
        .clki    (clki),
        .rst     (rst),
        .i_clr   (w_arm_ok),
        .i_shift (w_sample),
        .i_bit   (r_sync[2]),
        .o_bit   (w_d)
    );

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sync       <= '0;
            r_phase      <= '0;
            r_wait_cnt   <= '0;
            r_len        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_sync       <= {r_sync[1:0], bus.rx_in};
            r_byte_valid <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_timeout    <= 1'b0;

            if (r_pkt_done || r_timeout) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_arm_ok) begin
                        r_len       <= bus.payload_bits;
                        r_err_count <= '0;
                        r_bit_idx   <= '0;
                        r_wait_cnt  <= '0;
                        r_busy      <= 1'b1;
                        if (bus.payload_bits == '0) begin
                            r_pkt_done <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_EDGE;
                        end
                    end
                end

                ST_WAIT_EDGE: begin
                    // Edge takes priority over the final wait cycle.
                    if (w_edge) begin
                        r_state <= ST_SAMPLE;
                        r_phase <= PHASE_HALF;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (r_phase != '0) begin
                        r_phase <= r_phase - 16'd1;
                    end else begin
                        r_phase   <= PHASE_RELOAD;
                        r_shift   <= w_byte_next;
                        r_bit_idx <= r_bit_idx + 16'd1;
                        if ((w_d != w_exp) && (r_err_count != 16'hFFFF)) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        if (w_byte_full || w_last) begin
                            r_byte_data  <= w_byte_out;
                            r_byte_valid <= 1'b1;
                        end
                        if (w_last) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.byte_data  = r_byte_data;
    assign bus.byte_valid = r_byte_valid;
    assign bus.pkt_done   = r_pkt_done;
    assign bus.timeout    = r_timeout;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_wu_pkt_receiver.sv
// -----------------------------------------------------------------------------
// tb_wu_pkt_receiver
// Drives scrambled packets bit-by-bit and compares the receiver's bytes,
// error count and control pulses against a reference model that scrambles
// and descrambles whole bit arrays.
// -----------------------------------------------------------------------------
module tb_wu_pkt_receiver;

    localparam int D  = 8;
    localparam int TO = 4000;

    logic clki = 1'b0;
    logic rst  = 1'b1;

    wu_pkt_receiver_if bus ();

    wu_pkt_receiver #(
        .datarate_div (D),
        .timeout_cyc  (TO)
    ) dut (
        .clki (clki),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clki = ~clki;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    always @(posedge clki) cyc <= cyc + 1;

    // Monitor state, sampled on the falling edge.
    logic [7:0] got_bytes[$];
    int         done_cnt;
    logic       done_valid;
    int         to_cnt;
    int         to_cyc;
    int         arm_cyc;

    always @(negedge clki) begin
        if (bus.byte_valid) got_bytes.push_back(bus.byte_data);
        if (bus.pkt_done) begin
            done_cnt++;
            done_valid = bus.byte_valid;
        end
        if (bus.timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    // Reference model data.
    bit         chan[$];
    logic [7:0] exp_bytes[$];
    int         exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    task automatic clr_mon();
        got_bytes.delete();
        done_cnt   = 0;
        done_valid = 1'b0;
        to_cnt     = 0;
        to_cyc     = 0;
    endtask

    function automatic bit pattern_bit(input int k);
        return (k % 8) < 4;
    endfunction

    function automatic bit cb(input int j);
        return (j >= 0) ? chan[j] : 1'b0;
    endfunction

    // Scrambler/descrambler relation: channel bit k relates to data bit k
    // through channel bits k-1, k-4, k-5, k-7, k-8.
    function automatic bit taps(input int k);
        return cb(k - 1) ^ cb(k - 4) ^ cb(k - 5) ^ cb(k - 7) ^ cb(k - 8);
    endfunction

    function automatic void build(input int len, input bit rnd);
        chan.delete();
        for (int k = 0; k < len; k++) begin
            bit d;
            d = rnd ? ((k == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : pattern_bit(k);
            chan.push_back(d ^ taps(k));
        end
    endfunction

    function automatic void model(input int len);
        logic [7:0] b;
        b = '0;
        exp_bytes.delete();
        exp_err = 0;
        for (int k = 0; k < len; k++) begin
            bit d;
            d = chan[k] ^ taps(k);
            if (d != pattern_bit(k)) exp_err++;
            b[7 - (k % 8)] = d;
            if ((k % 8 == 7) || (k == len - 1)) begin
                exp_bytes.push_back(b);
                b = '0;
            end
        end
    endfunction

    task automatic do_arm(input int len);
        bus.arm          = 1'b1;
        bus.payload_bits = 16'(len);
        tick();
        arm_cyc = cyc;
        bus.arm = 1'b0;
    endtask

    // Arms, waits pre_cyc clocks with rx_in low, then drives chan[] at D clocks
    // per bit. Optionally pulses arm or asserts rst at the start of a bit.
    task automatic send(input int len, input int pre_cyc, input int arm_at, input int rst_at);
        clr_mon();
        do_arm(len);
        check("busy_rise", 32'(bus.busy), 32'd1);
        bus.rx_in = 1'b0;
        repeat (pre_cyc) tick();
        for (int k = 0; k < chan.size(); k++) begin
            for (int j = 0; j < D; j++) begin
                bus.rx_in = chan[k];
                if (k == arm_at && j == 0) begin
                    bus.arm          = 1'b1;
                    bus.payload_bits = 16'd3;
                end else begin
                    bus.arm = 1'b0;
                end
                if (k == rst_at && j == 0) begin
                    check("err_before_rst", 32'(bus.err_count != 0), 32'd1);
                    rst = 1'b1;
                    #1;
                    check("rst_outputs", 32'({bus.busy, bus.byte_valid, bus.pkt_done,
                          bus.timeout, bus.byte_data, bus.err_count}), 32'd0);
                    tick();
                    rst       = 1'b0;
                    bus.rx_in = 1'b0;
                    return;
                end
                tick();
            end
        end
        bus.rx_in = 1'b0;
        bus.arm   = 1'b0;
    endtask

    task automatic finish_pkt();
        for (int i = 0; i < 8 * D && done_cnt == 0; i++) tick();
        tick();
        tick();
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("done_with_valid", 32'(done_valid), 32'd1);
        check("n_bytes", 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check($sformatf("byte%0d", i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
        check("err_count", 32'(bus.err_count), 32'(exp_err));
        check("busy_fall", 32'(bus.busy), 32'd0);
    endtask

    task automatic run(input int len, input bit rnd, input int flip_at,
                       input int pre_cyc, input int arm_at);
        build(len, rnd);
        if (flip_at >= 0) chan[flip_at] = ~chan[flip_at];
        model(len);
        send(len, pre_cyc, arm_at, -1);
        finish_pkt();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.arm          = 1'b0;
        bus.rx_in        = 1'b0;
        bus.payload_bits = '0;
        clr_mon();
        repeat (3) tick();
        check("reset_outputs", 32'({bus.busy, bus.byte_valid, bus.pkt_done,
              bus.timeout, bus.byte_data, bus.err_count}), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Zero-length request completes immediately without a byte.
        clr_mon();
        do_arm(0);
        check("len0_done", 32'(bus.pkt_done), 32'd1);
        check("len0_valid", 32'(bus.byte_valid), 32'd0);
        tick();
        check("len0_done_clr", 32'(bus.pkt_done), 32'd0);
        check("len0_busy", 32'(bus.busy), 32'd0);
        repeat (3) tick();

        // Clean 64-bit packet after 432 zero preamble bits.
        run(64, 1'b0, -1, 432 * D, -1);
        check("clean_err", 32'(bus.err_count), 32'd0);
        for (int i = 0; i < got_bytes.size(); i++)
            check("clean_f0", 32'(got_bytes[i]), 32'h0F0);

        // Single channel error at payload index 20 multiplies to 6 bit errors.
        run(64, 1'b0, 20, 432 * D, -1);
        check("flip20_err", 32'(bus.err_count), 32'd6);

        // 12-bit packet: one full byte and a zero-padded nibble.
        run(12, 1'b0, -1, 5 * D, -1);
        check("len12_n", 32'(got_bytes.size()), 32'd2);
        check("len12_b1", 32'(got_bytes[1]), 32'h0F0);

        // No edge at all: timeout exactly TO clocks after arming.
        clr_mon();
        do_arm(16);
        for (int i = 0; i < TO + 20 && to_cnt == 0; i++) tick();
        check("to_seen", 32'(to_cnt), 32'd1);
        check("to_latency", 32'(to_cyc - arm_cyc), 32'(TO));
        check("to_no_bytes", 32'(got_bytes.size()), 32'd0);
        tick();
        check("to_busy", 32'(bus.busy), 32'd0);
        repeat (5) tick();

        // Edge detected one cycle too late still times out.
        clr_mon();
        do_arm(16);
        repeat (TO - 2) tick();
        bus.rx_in = 1'b1;
        for (int i = 0; i < 20 && to_cnt == 0; i++) tick();
        check("late_to_latency", 32'(to_cyc - arm_cyc), 32'(TO));
        repeat (2 * D) tick();
        bus.rx_in = 1'b0;
        repeat (2 * D) tick();
        check("late_no_bytes", 32'(got_bytes.size() + done_cnt), 32'd0);

        // Edge detected in the last wait cycle takes the sync path.
        run(16, 1'b0, -1, TO - 3, -1);
        check("edge_at_limit_no_to", 32'(to_cnt), 32'd0);

        // Reset mid-packet aborts; the next packet is clean.
        build(64, 1'b0);
        chan[2] = ~chan[2];
        send(64, 4 * D, -1, 20);
        repeat (4 * D) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        run(64, 1'b0, -1, 6 * D, -1);
        check("after_rst_err", 32'(bus.err_count), 32'd0);

        // Edge before arm and arm during SAMPLE are both ignored.
        bus.rx_in = 1'b1;
        repeat (2 * D) tick();
        bus.rx_in = 1'b0;
        repeat (10) tick();
        run(24, 1'b0, -1, 3 * D, 5);
        check("rearm_ignored_n", 32'(got_bytes.size()), 32'd3);

        // Randomised payloads, lengths, preambles and channel errors.
        for (int n = 0; n < 12; n++) begin
            int len;
            int flip;
            len  = $urandom_range(1, 40);
            flip = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : -1;
            run(len, 1'($urandom_range(0, 1)), flip, $urandom_range(8, 20 * D),
                (len > 2) ? $urandom_range(1, len - 1) : -1);
            repeat ($urandom_range(3, 12)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wu_pkt_receiver.md
# wu_pkt_receiver

Receive-side counterpart of the wake-up sync/packet generator. The block samples the comparator-driven serial stream after an armed wake-up, locks bit timing to the first rising edge that follows the all-zero preamble, and self-synchronously descrambles the payload with the x^8-tap scrambler. It delivers payload bytes, checks every bit against the fixed 1111_0000 test pattern, and reports packet completion or timeout to the control logic.

## Interface
- `datarate_div`, default 100: system clocks per data bit. Must be even and ≥ 4.
- `timeout_cyc`, default 1000000: maximum number of clocks to wait for the sync edge after arming.
- `clki`  in  1: system clock (100 MHz).
- `rst`  in  1: reset, asynchronous, active-high.
- `arm`  in  1: single-cycle start request. Accepted only in IDLE.
- `rx_in`  in  1: raw comparator output, asynchronous to `clki`.
- `payload_bits`  in  16: payload length in bits. Sampled when `arm` is accepted.
- `busy`  out  1: high from the cycle after `arm` is accepted until the cycle after `pkt_done` or `timeout` pulses.
- `byte_data`  out  8: received byte. The first received bit is placed in bit 7.
- `byte_valid`  out  1: one-cycle strobe qualifying `byte_data`.
- `pkt_done`  out  1: one-cycle pulse when the last payload bit has been processed.
- `timeout`  out  1: one-cycle pulse when the sync edge did not arrive in time.
- `err_count`  out  16: number of descrambled bits that differ from the pattern. Saturates at 0xFFFF.

## Operation
- Input conditioning: `rx_in` passes through a 3-flop synchronizer `s[2:0]`. A rising edge is detected when `s[2:1]==2'b01`.
- States:
  - IDLE
  - WAIT_EDGE
  - SAMPLE
- Transitions:
  - IDLE -> WAIT_EDGE on `arm`. On acceptance: latch `payload_bits`, clear `err_count`, clear history and the bit index, clear the wait counter.
  - IDLE with `arm` and `payload_bits==0`: stay in IDLE and pulse `pkt_done` the next cycle.
  - WAIT_EDGE -> SAMPLE on a detected rising edge. On the same cycle, load `phase = datarate_div/2`.
  - WAIT_EDGE -> IDLE when the wait counter reaches `timeout_cyc`. Pulse `timeout` on that transition.
- SAMPLE:
  - `phase` decrements each cycle.
  - When `phase==0`: sample `r = s[2]` and reload `phase = datarate_div-1`.
  - Descrambled bit: `d = r ^ h[0] ^ h[3] ^ h[4] ^ h[6] ^ h[7]`. Then shift: `h <= {h[6:0], r}`. History is zero at sync, which matches the transmitter's scrambler being zero through the preamble.
  - Expected bit for index `i`: 1 if `(i mod 8) < 4`, else 0. A mismatch increments `err_count` with saturation.
  - `d` shifts into the byte assembler MSB-first.
- Byte output:
  - After every 8th bit, present the byte and strobe `byte_valid`.
  - On the final bit, if the byte is partial, emit it left-aligned with zero padding.
  - `pkt_done` pulses in the same cycle as the final `byte_valid`. The state then returns to IDLE.
- Rising edges seen during SAMPLE are ignored. Bit timing free-runs from the single sync edge.
- `arm` is ignored while `busy` is high.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer/history/counters 0.
- `rst` overrides `arm` in the same cycle. Asserting `rst` mid-packet aborts immediately with no `pkt_done`.
- Edge detect occurs 3 clocks after `rx_in` rises (synchronizer latency).
- Bit `k` (k from 0) is sampled `datarate_div/2 + k*datarate_div` clocks after the edge-detect cycle.
- `byte_valid`, `pkt_done` and the `err_count` update are registered. They appear 1 clock after the sampling cycle.
- `busy` rises 1 clock after `arm` is accepted.
- Total packet time: last sample at `datarate_div/2 + (payload_bits-1)*datarate_div`. `pkt_done` follows 1 clock later.
- Wait counter boundary: an edge detected in the same cycle the counter hits `timeout_cyc` takes the sync path; no `timeout` pulse is generated.

## Structure
- Package `wu_pkt_pkg` holds:
  - the state enum
  - `SCR_TAPS = 8'hD9` (taps h0, h3, h4, h6, h7)
  - `PATTERN = 8'hF0`
- Sub-module `rx_descrambler` contains:
  - the 8-bit history register
  - the XOR tap network
  - a shift-enable port and a clear port
- The top level holds the FSM, phase counter, wait counter, bit index, byte assembler and error counter.

## Test plan
- Clean packet, `payload_bits=64`: the bench scrambles `{F0}x8` and drives it after 432 zero bits. Required: 8 `byte_valid` strobes, each with 0xF0; `err_count=0`; `pkt_done` with the last byte.
- Same packet with the channel bit at payload index 20 inverted. Required: `err_count=6` (error multiplication over taps 0, 1, 4, 5, 7, 8).
- `payload_bits=12`. Required: bytes 0xF0 then 0xF0 (the partial byte 1111 is zero-padded to 0xF0); exactly 2 strobes.
- Arm with no edge on `rx_in`. Required: `timeout` pulses exactly `timeout_cyc` clocks after WAIT_EDGE entry; no `byte_valid`; return to IDLE.
- `rst` asserted mid-SAMPLE, then re-arm and send a clean packet. Required: immediate abort with all outputs 0; the second packet is received error-free.
- Edge on `rx_in` before `arm`, and `arm` pulsed during SAMPLE. Both are ignored, and the packet is received unchanged.
